// File: rtl/uart_pkg.sv
// Shared UART parity definitions: parity modes, minimum data width and helpers
// used by both the TX generator and the RX checker.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_mode_e;

    localparam int MIN_DATA_WD = 5;

    // Callers zero-extend their data into the 16-bit argument; unused bits do not
    // disturb the XOR.
    function automatic logic exp_parity(input logic [15:0] data, input par_mode_e mode);
        logic p;
        case (mode)
            PAR_EVEN:  p = ^data;
            PAR_ODD:   p = ~(^data);
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b0;
        endcase
        return p;
    endfunction

    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_wd);
        logic [3:0] r;
        if (int'(len) < MIN_DATA_WD)
            r = 4'(MIN_DATA_WD);
        else if (int'(len) > max_wd)
            r = 4'(max_wd);
        else
            r = len;
        return r;
    endfunction

endpackage

// File: rtl/parity_rx_chk.sv
// Bit-serial RX parity checker: frame FSM, running XOR accumulator, bit counter
// and a saturating parity-error counter.
module parity_rx_chk
    import uart_pkg::*;
#(
    parameter int CNT_WD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              par_en,
    input  par_mode_e         par_mode,
    input  logic [3:0]        data_len,
    input  logic              frame_start,
    input  logic              bit_strobe,
    input  logic              bit_in,
    input  logic              err_clr,
    output logic              par_done,
    output logic              par_err,
    output logic [CNT_WD-1:0] err_count
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] ACCUM    = 2'd1;
    localparam logic [1:0] WAIT_PAR = 2'd2;
    localparam logic [1:0] REPORT   = 2'd3;

    logic [1:0] state;
    logic       acc;
    logic [3:0] cnt;
    logic       en_s;
    par_mode_e  mode_s;
    logic [3:0] len_s;
    logic       mismatch;

    // frame_start overrides every state, so an abort never reaches REPORT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= 1'b0;
            cnt      <= 4'd0;
            en_s     <= 1'b0;
            mode_s   <= PAR_EVEN;
            len_s    <= 4'(MIN_DATA_WD);
            mismatch <= 1'b0;
        end else if (frame_start) begin
            state  <= ACCUM;
            acc    <= 1'b0;
            cnt    <= 4'd0;
            en_s   <= par_en;
            mode_s <= par_mode;
            len_s  <= data_len;
        end else begin
            case (state)
                ACCUM: begin
                    if (bit_strobe) begin
                        acc <= acc ^ bit_in;
                        cnt <= cnt + 4'd1;
                        if (cnt + 4'd1 == len_s)
                            state <= en_s ? WAIT_PAR : IDLE;
                    end
                end
                WAIT_PAR: begin
                    if (bit_strobe) begin
                        mismatch <= (bit_in != exp_parity({15'd0, acc}, mode_s));
                        state    <= REPORT;
                    end
                end
                REPORT:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign par_done = (state == REPORT);
    assign par_err  = par_done & mismatch;

    always_ff @(posedge clk) begin
        if (!rst_n)
            err_count <= '0;
        else if (err_clr)
            err_count <= '0;
        else if (par_err && (err_count != {CNT_WD{1'b1}}))
            err_count <= err_count + 1'b1;
    end

endmodule

// File: rtl/parity_engine.sv
// UART parity unit: registered TX parity generator with runtime data length,
// plus an independent bit-serial RX parity checker.
module parity_engine
    import uart_pkg::*;
#(
    parameter int MAX_WD = 9,
    parameter int CNT_WD = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PAR_EN,
    input  logic [1:0]        PAR_MODE,
    input  logic [3:0]        DATA_LEN,
    input  logic [MAX_WD-1:0] P_DATA,
    input  logic              Data_Valid,
    output logic              par_bit,
    output logic              par_valid,
    input  logic              frame_start,
    input  logic              bit_strobe,
    input  logic              bit_in,
    output logic              par_done,
    output logic              par_err,
    input  logic              err_clr,
    output logic [CNT_WD-1:0] err_count
);

    logic [3:0]        len_eff;
    logic [MAX_WD-1:0] masked;
    logic [MAX_WD-1:0] tx_data;
    logic              tx_en;
    par_mode_e         tx_mode;
    logic              tx_load;

    assign len_eff = clamp_len(DATA_LEN, MAX_WD);

    always_comb begin
        masked = '0;
        for (int i = 0; i < MAX_WD; i++)
            if (i < int'(len_eff))
                masked[i] = P_DATA[i];
    end

    // Stage 1 snapshots the word and config; stage 2 publishes the parity bit.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            tx_load   <= 1'b0;
            tx_en     <= 1'b0;
            tx_mode   <= PAR_EVEN;
            tx_data   <= '0;
            par_bit   <= 1'b0;
            par_valid <= 1'b0;
        end else begin
            tx_load   <= Data_Valid;
            par_valid <= tx_load & tx_en;
            if (Data_Valid) begin
                tx_en   <= PAR_EN;
                tx_mode <= par_mode_e'(PAR_MODE);
                tx_data <= masked;
            end
            if (tx_load)
                par_bit <= tx_en ? exp_parity(16'(tx_data), tx_mode) : 1'b0;
        end
    end

    parity_rx_chk #(
        .CNT_WD(CNT_WD)
    ) u_rx_chk (
        .clk        (CLK),
        .rst_n      (RST),
        .par_en     (PAR_EN),
        .par_mode   (par_mode_e'(PAR_MODE)),
        .data_len   (len_eff),
        .frame_start(frame_start),
        .bit_strobe (bit_strobe),
        .bit_in     (bit_in),
        .err_clr    (err_clr),
        .par_done   (par_done),
        .par_err    (par_err),
        .err_count  (err_count)
    );

endmodule

// File: tb/tb_parity_engine.sv
// Directed bench for parity_engine: TX vector table plus hand-written RX frame,
// abort, reset and saturating-counter sequences.
module tb_parity_engine;
    import uart_pkg::*;

    localparam int MAX_WD = 9;
    localparam int CNT_WD = 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic              PAR_EN = 1'b0;
    logic [1:0]        PAR_MODE = 2'b00;
    logic [3:0]        DATA_LEN = 4'd8;
    logic [MAX_WD-1:0] P_DATA = '0;
    logic              Data_Valid = 1'b0;
    logic              par_bit;
    logic              par_valid;
    logic              frame_start = 1'b0;
    logic              bit_strobe = 1'b0;
    logic              bit_in = 1'b0;
    logic              par_done;
    logic              par_err;
    logic              err_clr = 1'b0;
    logic [CNT_WD-1:0] err_count;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic [3:0] len;
        logic [8:0] data;
        logic       exp_bit;
        logic       exp_valid;
    } tx_vec_t;

    tx_vec_t tx_vecs[10];

    parity_engine #(
        .MAX_WD(MAX_WD),
        .CNT_WD(CNT_WD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PAR_EN     (PAR_EN),
        .PAR_MODE   (PAR_MODE),
        .DATA_LEN   (DATA_LEN),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .par_bit    (par_bit),
        .par_valid  (par_valid),
        .frame_start(frame_start),
        .bit_strobe (bit_strobe),
        .bit_in     (bit_in),
        .par_done   (par_done),
        .par_err    (par_err),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        if (par_done === 1'b1)
            done_cnt++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Config inputs are scrambled right after the snapshot edge to prove it was taken.
    task automatic rx_start(input logic en, input logic [1:0] mode, input logic [3:0] len);
        @(negedge CLK);
        PAR_EN = en; PAR_MODE = mode; DATA_LEN = len; frame_start = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0; PAR_EN = ~en; PAR_MODE = mode ^ 2'b11; DATA_LEN = 4'd9;
    endtask

    task automatic rx_bit(input logic b);
        @(negedge CLK);
        bit_strobe = 1'b1; bit_in = b;
        @(negedge CLK);
        bit_strobe = 1'b0; bit_in = 1'b0;
    endtask

    task automatic rx_data(input logic [8:0] data, input int n);
        for (int i = 0; i < n; i++)
            rx_bit(data[i]);
    endtask

    task automatic check_report(input string name, input logic exp_err, input logic [CNT_WD-1:0] exp_cnt);
        check_output({name, "_done"}, par_done, 1'b1);
        check_output({name, "_err"}, par_err, exp_err);
        tick(1);
        check_output({name, "_done_drop"}, par_done, 1'b0);
        check_output({name, "_count"}, err_count, exp_cnt);
    endtask

    task automatic err_frame();
        rx_start(1'b1, 2'b00, 4'd5);
        rx_data(9'h000, 5);
        rx_bit(1'b1);
    endtask

    initial begin
        int base;
        tx_vecs[0] = '{1'b1, 2'b00, 4'd8,  9'h0A5, 1'b0, 1'b1};
        tx_vecs[1] = '{1'b1, 2'b01, 4'd8,  9'h0A5, 1'b1, 1'b1};
        tx_vecs[2] = '{1'b1, 2'b00, 4'd7,  9'h080, 1'b0, 1'b1};
        tx_vecs[3] = '{1'b1, 2'b00, 4'd3,  9'h010, 1'b1, 1'b1};
        tx_vecs[4] = '{1'b1, 2'b10, 4'd8,  9'h000, 1'b1, 1'b1};
        tx_vecs[5] = '{1'b0, 2'b01, 4'd8,  9'h001, 1'b0, 1'b0};
        tx_vecs[6] = '{1'b1, 2'b11, 4'd8,  9'h0FF, 1'b0, 1'b1};
        tx_vecs[7] = '{1'b1, 2'b00, 4'd15, 9'h100, 1'b1, 1'b1};
        tx_vecs[8] = '{1'b1, 2'b01, 4'd9,  9'h1FF, 1'b0, 1'b1};
        tx_vecs[9] = '{1'b1, 2'b01, 4'd5,  9'h1E0, 1'b1, 1'b1};

        tick(2);
        check_output("rst_par_bit", par_bit, 1'b0);
        check_output("rst_par_valid", par_valid, 1'b0);
        check_output("rst_par_done", par_done, 1'b0);
        check_output("rst_par_err", par_err, 1'b0);
        check_output("rst_err_count", err_count, 2'd0);
        RST = 1'b1;
        tick(1);

        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            PAR_EN = tx_vecs[i].en; PAR_MODE = tx_vecs[i].mode;
            DATA_LEN = tx_vecs[i].len; P_DATA = tx_vecs[i].data; Data_Valid = 1'b1;
            @(negedge CLK);
            Data_Valid = 1'b0; P_DATA = 9'h1FF;
            PAR_EN = ~tx_vecs[i].en; PAR_MODE = tx_vecs[i].mode ^ 2'b01;
            check_output($sformatf("tx%0d_valid_early", i), par_valid, 1'b0);
            @(negedge CLK);
            check_output($sformatf("tx%0d_bit", i), par_bit, tx_vecs[i].exp_bit);
            check_output($sformatf("tx%0d_valid", i), par_valid, tx_vecs[i].exp_valid);
            @(negedge CLK);
            check_output($sformatf("tx%0d_valid_drop", i), par_valid, 1'b0);
            check_output($sformatf("tx%0d_bit_hold", i), par_bit, tx_vecs[i].exp_bit);
        end

        // Back-to-back loads: odd 0x0A5 (1) then even 0x0A5 (0).
        @(negedge CLK);
        PAR_EN = 1'b1; PAR_MODE = 2'b01; DATA_LEN = 4'd8; P_DATA = 9'h0A5; Data_Valid = 1'b1;
        @(negedge CLK);
        PAR_MODE = 2'b00;
        @(negedge CLK);
        Data_Valid = 1'b0;
        check_output("b2b_first_bit", par_bit, 1'b1);
        check_output("b2b_first_valid", par_valid, 1'b1);
        @(negedge CLK);
        check_output("b2b_second_bit", par_bit, 1'b0);
        check_output("b2b_second_valid", par_valid, 1'b1);
        @(negedge CLK);
        check_output("b2b_valid_drop", par_valid, 1'b0);

        rx_start(1'b1, 2'b00, 4'd8);
        rx_data(9'h003, 8);
        rx_bit(1'b1);
        check_report("rx_even_bad", 1'b1, 2'd1);

        rx_start(1'b1, 2'b00, 4'd8);
        rx_data(9'h003, 8);
        rx_bit(1'b0);
        check_report("rx_even_ok", 1'b0, 2'd1);

        rx_start(1'b1, 2'b10, 4'd5);
        rx_data(9'h016, 5);
        rx_bit(1'b0);
        check_report("rx_mark_bad", 1'b1, 2'd2);

        base = done_cnt;
        rx_start(1'b0, 2'b00, 4'd5);
        rx_data(9'h016, 5);
        rx_bit(1'b1);
        tick(3);
        check_output("rx_noparity_done_cnt", done_cnt, base);
        check_output("rx_noparity_count", err_count, 2'd2);

        base = done_cnt;
        rx_start(1'b1, 2'b00, 4'd8);
        rx_data(9'h001, 4);
        rx_start(1'b1, 2'b00, 4'd8);
        rx_data(9'h007, 8);
        rx_bit(1'b1);
        check_report("rx_abort_restart", 1'b0, 2'd2);
        tick(1);
        check_output("rx_abort_done_cnt", done_cnt, base + 1);

        rx_start(1'b1, 2'b01, 4'd9);
        rx_data(9'h1FF, 9);
        rx_bit(1'b0);
        check_report("rx_odd9_ok", 1'b0, 2'd2);

        base = done_cnt;
        rx_start(1'b1, 2'b00, 4'd8);
        rx_data(9'h005, 3);
        @(negedge CLK); RST = 1'b0;
        @(negedge CLK); RST = 1'b1;
        check_output("rx_rst_done", par_done, 1'b0);
        check_output("rx_rst_count", err_count, 2'd0);
        rx_data(9'h0FF, 6);
        tick(3);
        check_output("rx_rst_done_cnt", done_cnt, base);

        for (int k = 0; k < 5; k++) begin
            err_frame();
            check_report($sformatf("sat%0d", k), 1'b1, (k < 2) ? 2'(k + 1) : 2'd3);
        end

        @(negedge CLK); err_clr = 1'b1;
        @(negedge CLK); err_clr = 1'b0;
        check_output("clr_alone", err_count, 2'd0);

        err_frame();
        check_report("clr_pre", 1'b1, 2'd1);

        err_frame();
        check_output("clr_race_done", par_done, 1'b1);
        check_output("clr_race_err", par_err, 1'b1);
        err_clr = 1'b1;
        @(negedge CLK); err_clr = 1'b0;
        check_output("clr_race_count", err_count, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/parity_engine.md
Name: parity_engine

Overview:
Parametrised UART parity unit that supersedes the fixed-width even/odd generator. It does two jobs with independent paths:
- TX: generates the parity bit from a parallel word, with the data length selectable at runtime and four parity modes.
- RX: checks parity bit-serially as the receiver samples each bit, reports a per-frame error, and keeps a saturating error counter.

It sits between the UART TX/RX framers and the config register block.

Parameters:
MAX_WD, 9, widest supported data field in bits (legal range 5..9)
CNT_WD, 8, width of the saturating RX parity-error counter

Ports:
CLK  input  1  clock
RST  input  1  synchronous reset, active-low
PAR_EN  input  1  parity enable
PAR_MODE  input  2  00 even, 01 odd, 10 mark (always 1), 11 space (always 0)
DATA_LEN  input  4  runtime data length in bits
P_DATA  input  MAX_WD  TX parallel data, LSB = first bit on line
Data_Valid  input  1  TX load strobe
par_bit  output  1  TX parity bit (registered)
par_valid  output  1  one-cycle pulse: par_bit updated
frame_start  input  1  RX start bit detected
bit_strobe  input  1  RX mid-bit sample strobe
bit_in  input  1  RX sampled line value
par_done  output  1  one-cycle pulse: RX parity check complete
par_err  output  1  RX check result, valid while par_done = 1
err_clr  input  1  clear the error counter
err_count  output  CNT_WD  saturating RX parity-error count

Behaviour:
- Reset: RST is sampled on the CLK edge.
  - RST = 0 drives par_bit, par_valid, par_done, par_err and err_count to 0 and returns the RX FSM to IDLE.
  - Reset mid-frame discards the frame with no report.
- DATA_LEN clamping: values < 5 are treated as 5; values > MAX_WD are treated as MAX_WD. Clamping applies to both paths.
- TX path:
  - On edge N with Data_Valid = 1: capture P_DATA with bits at or above DATA_LEN forced to 0. PAR_EN, PAR_MODE and DATA_LEN are snapshotted at the same edge.
  - On edge N+1: par_bit is updated. par_valid = 1 for exactly one cycle, only if the snapshotted PAR_EN = 1.
  - If the snapshotted PAR_EN = 0: par_bit is 0 and there is no par_valid pulse.
  - Parity value per mode: even = XOR of masked bits; odd = its inverse; mark = 1; space = 0.
  - par_bit holds its value until the next load.
  - Back-to-back Data_Valid on consecutive cycles is legal; each load produces its own result one cycle later.
- RX FSM states: IDLE, ACCUM, WAIT_PAR, REPORT.
  - IDLE -> ACCUM on frame_start. Clear the accumulator and bit counter; snapshot PAR_EN, PAR_MODE and DATA_LEN.
  - ACCUM: each bit_strobe XORs bit_in into the accumulator and increments the counter. When the counter reaches DATA_LEN: go to WAIT_PAR if PAR_EN = 1, otherwise go to IDLE silently.
  - WAIT_PAR: the next bit_strobe samples the received parity bit. Compare it with the expected bit (same mode rules as TX) and go to REPORT.
  - REPORT, one cycle: par_done = 1 and par_err = mismatch; then go to IDLE. Outside REPORT, par_done = 0 and par_err = 0.
  - frame_start in ACCUM, WAIT_PAR or REPORT aborts the current frame with no report and restarts in ACCUM. If REPORT is being entered on the same edge, frame_start wins: no par_done.
  - frame_start and bit_strobe in the same cycle: frame_start wins and the strobe is ignored.
  - bit_strobe in IDLE is ignored.
- Error counter:
  - Increments on REPORT with a mismatch, saturating at 2^CNT_WD - 1.
  - err_clr forces 0 on the next edge. err_clr wins over a simultaneous increment.
- TX and RX paths are fully independent and may be active in the same cycle.

Decomposition:
- Shared package uart_pkg:
  - par_mode_e enum (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE)
  - MIN_DATA_WD = 5
  - A function exp_parity(data, mode) used by both paths.
- One sub-module, parity_rx_chk: the RX FSM, accumulator, bit counter and error counter. The TX path stays in the top module.

Test Plan:
- TX: PAR_EN = 1, DATA_LEN = 8, P_DATA = 9'h0A5, even -> par_bit = 0 with par_valid one cycle after Data_Valid. Same data, odd -> par_bit = 1.
- TX masking: DATA_LEN = 7, P_DATA = 9'h080, even -> par_bit = 0. DATA_LEN = 3 (clamped to 5), P_DATA = 9'h010, even -> par_bit = 1.
- RX: even, DATA_LEN = 8, bits of 8'h03 LSB-first, then parity bit 1 -> par_done pulse with par_err = 1, err_count = 1. Parity bit 0 instead -> par_err = 0, err_count unchanged.
- RX mark mode, DATA_LEN = 5, received parity 0 -> par_err = 1. PAR_EN = 0 -> no par_done after 5 strobes.
- Abort/reset: frame_start after 4 of 8 bits restarts the frame, and the restarted frame checks correctly. RST = 0 mid-frame -> IDLE, no par_done, err_count = 0.
- Counter: CNT_WD = 2, five error frames -> err_count = 3. err_clr in the same cycle as an error REPORT -> err_count = 0.
